// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: default sizes, MIDI constants and
// the allocator FSM state type.
package synth_pkg;

  localparam int unsigned VOICES_DEFAULT  = 8;
  localparam int unsigned V_WIDTH_DEFAULT = 3;
  localparam logic [6:0]  MIDI_CC_SUSTAIN = 7'd64;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit
  } alloc_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters: the assigned voice restarts at zero while every
// other gated voice gets one step older.
module voice_age_tracker
  import synth_pkg::*;
#(
  parameter int unsigned VOICES  = VOICES_DEFAULT,
  parameter int unsigned V_WIDTH = V_WIDTH_DEFAULT,
  parameter int unsigned AGE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     assign_en,
  input  logic [V_WIDTH-1:0]       assign_idx,
  input  logic [VOICES-1:0]        active,
  output logic [VOICES*AGE_W-1:0]  age
);

  localparam logic [AGE_W-1:0] AgeMax = '1;

  logic [AGE_W-1:0] age_q [VOICES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) age_q[v] <= '0;
    end else if (assign_en) begin
      for (int v = 0; v < VOICES; v++) begin
        if (V_WIDTH'(v) == assign_idx) begin
          age_q[v] <= '0;
        end else if (active[v] && age_q[v] != AgeMax) begin
          age_q[v] <= age_q[v] + AGE_W'(1);
        end
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_age
    assign age[v*AGE_W +: AGE_W] = age_q[v];
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then retriggers a matching
// voice, takes the lowest free one, or steals the oldest.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned VOICES    = VOICES_DEFAULT,
  parameter int unsigned V_WIDTH   = V_WIDTH_DEFAULT,
  parameter int unsigned AGE_W     = 8,
  parameter int unsigned PULSE_LEN = 1024
) (
  input  logic               sys_clk,
  input  logic               iRST_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_is_on,
  input  logic [6:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               sustain,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);

  localparam int unsigned        CntW    = $clog2(PULSE_LEN + 1);
  localparam logic [V_WIDTH-1:0] LastIdx = V_WIDTH'(VOICES - 1);

  alloc_state_t         state_q;
  logic [V_WIDTH-1:0]   scan_idx_q;
  logic                 ev_on_q;
  logic [6:0]           ev_key_q;
  logic [7:0]           ev_vel_q;
  logic [6:0]           key_tbl_q [VOICES];
  logic [VOICES-1:0]    pend_q;
  logic                 sustain_q;
  logic                 match_found_q, free_found_q;
  logic [V_WIDTH-1:0]   match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0]     old_age_q;
  logic [CntW-1:0]      pulse_cnt_q;

  logic [VOICES*AGE_W-1:0] ages;
  logic [AGE_W-1:0]        scan_age;
  logic [V_WIDTH-1:0]      target;
  logic                    assign_en, sus_fall, hit, vacant;

  assign scan_age  = ages[scan_idx_q*AGE_W +: AGE_W];
  assign hit       = (keys_on[scan_idx_q] | pend_q[scan_idx_q]) &&
                     (key_tbl_q[scan_idx_q] == ev_key_q);
  assign vacant    = !keys_on[scan_idx_q] && voice_free[scan_idx_q];
  assign target    = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);
  assign assign_en = (state_q == StCommit) && ev_on_q;
  assign sus_fall  = sustain_q && !sustain;
  assign note_on   = (pulse_cnt_q != '0);

  voice_age_tracker #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH),
    .AGE_W   (AGE_W)
  ) u_age (
    .clk        (sys_clk),
    .rst_n      (iRST_N),
    .assign_en  (assign_en),
    .assign_idx (target),
    .active     (keys_on),
    .age        (ages)
  );

  always_ff @(posedge sys_clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q       <= StIdle;
      scan_idx_q    <= '0;
      ev_on_q       <= 1'b0;
      ev_key_q      <= '0;
      ev_vel_q      <= '0;
      for (int v = 0; v < VOICES; v++) key_tbl_q[v] <= '0;
      pend_q        <= '0;
      sustain_q     <= 1'b0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      pulse_cnt_q   <= '0;
      ev_ready      <= 1'b1;
      keys_on       <= '0;
      cur_key_adr   <= '0;
      cur_key_val   <= '0;
      cur_vel_on    <= '0;
      cur_vel_off   <= '0;
    end else begin
      sustain_q <= sustain;
      if (pulse_cnt_q != '0) pulse_cnt_q <= pulse_cnt_q - CntW'(1);

      // Pedal release drops every held-over voice; a same-cycle commit below overrides it.
      if (sus_fall) begin
        keys_on <= keys_on & ~pend_q;
        pend_q  <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (ev_valid && ev_ready) begin
            ev_on_q       <= ev_is_on;
            ev_key_q      <= ev_key;
            ev_vel_q      <= ev_vel;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            scan_idx_q    <= '0;
            ev_ready      <= 1'b0;
            state_q       <= StScan;
          end
        end
        StScan: begin
          if (!match_found_q && hit) begin
            match_found_q <= 1'b1;
            match_idx_q   <= scan_idx_q;
          end
          if (!free_found_q && vacant) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
          end
          if (scan_idx_q == '0 || scan_age > old_age_q) begin
            old_idx_q <= scan_idx_q;
            old_age_q <= scan_age;
          end
          if (scan_idx_q == LastIdx) state_q <= StCommit;
          else scan_idx_q <= scan_idx_q + V_WIDTH'(1);
        end
        StCommit: begin
          state_q  <= StIdle;
          ev_ready <= 1'b1;
          if (ev_on_q) begin
            keys_on[target]   <= 1'b1;
            key_tbl_q[target] <= ev_key_q;
            pend_q[target]    <= 1'b0;
            cur_key_adr       <= target;
            cur_key_val       <= {1'b0, ev_key_q};
            cur_vel_on        <= ev_vel_q;
            pulse_cnt_q       <= CntW'(PULSE_LEN);
          end else if (match_found_q) begin
            if (sustain) pend_q[match_idx_q] <= 1'b1;
            else keys_on[match_idx_q] <= 1'b0;
            cur_key_adr <= match_idx_q;
            cur_vel_off <= ev_vel_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: vector table for allocation order plus hand
// sequences for pulse length, sustain release, reset mid-scan and retrigger reload.
module tb_voice_allocator;

  logic       sys_clk = 1'b0;
  logic       iRST_N = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic       ev_is_on = 1'b0;
  logic [6:0] ev_key = '0;
  logic [7:0] ev_vel = '0;
  logic       sustain = 1'b0;
  logic [7:0] voice_free = 8'hFF;
  logic [7:0] keys_on;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val;
  logic [7:0] cur_vel_on;
  logic [7:0] cur_vel_off;

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  voice_allocator #(
    .VOICES    (8),
    .V_WIDTH   (3),
    .AGE_W     (8),
    .PULSE_LEN (1024)
  ) dut (
    .sys_clk     (sys_clk),
    .iRST_N      (iRST_N),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_is_on    (ev_is_on),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .sustain     (sustain),
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off)
  );

  typedef struct packed {
    logic       on;
    logic [6:0] key;
    logic [7:0] vel;
    logic       sus;
    logic [7:0] vf;
    logic [7:0] e_keys;
    logic [2:0] e_adr;
    logic [7:0] e_val;
    logic [7:0] e_von;
    logic [7:0] e_voff;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Returns with outputs sampled just after the commit edge; lo counts ev_ready-low samples.
  task automatic send_event(input logic on, input logic [6:0] key, input logic [7:0] vel,
                            output int lo);
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while (!ev_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    ev_valid = 1'b1;
    ev_is_on = on;
    ev_key   = key;
    ev_vel   = vel;
    @(posedge sys_clk);
    #1;
    ev_valid = 1'b0;
    lo = 0;
    while (!ev_ready && lo < 100) begin
      lo++;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic measure_pulse(output int n);
    n = 0;
    while (note_on && n < 3000) begin
      n++;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " keys_on"}, 32'(keys_on), 32'h0);
    check({tag, " note_on"}, 32'(note_on), 32'h0);
    check({tag, " adr"}, 32'(cur_key_adr), 32'h0);
    check({tag, " key_val"}, 32'(cur_key_val), 32'h0);
    check({tag, " vel_on"}, 32'(cur_vel_on), 32'h0);
    check({tag, " vel_off"}, 32'(cur_vel_off), 32'h0);
    check({tag, " ev_ready"}, 32'(ev_ready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lo, plen;
    logic [6:0] k3 [3];
    k3 = '{7'd60, 7'd64, 7'd67};

    //        on    key    vel    sus   vf     keys   adr   val    von    voff
    vecs[0]  = '{1'b1, 7'd70, 8'd90, 1'b0, 8'hFF, 8'h0F, 3'd3, 8'd70, 8'd90, 8'd0};
    vecs[1]  = '{1'b1, 7'd72, 8'd91, 1'b0, 8'hFF, 8'h1F, 3'd4, 8'd72, 8'd91, 8'd0};
    vecs[2]  = '{1'b1, 7'd74, 8'd92, 1'b0, 8'hFF, 8'h3F, 3'd5, 8'd74, 8'd92, 8'd0};
    vecs[3]  = '{1'b1, 7'd76, 8'd93, 1'b0, 8'hFF, 8'h7F, 3'd6, 8'd76, 8'd93, 8'd0};
    vecs[4]  = '{1'b1, 7'd77, 8'd94, 1'b0, 8'hFF, 8'hFF, 3'd7, 8'd77, 8'd94, 8'd0};
    // 9th key with nothing free: voice 0 is the oldest
    vecs[5]  = '{1'b1, 7'd79, 8'd95, 1'b0, 8'h00, 8'hFF, 3'd0, 8'd79, 8'd95, 8'd0};
    vecs[6]  = '{1'b1, 7'd79, 8'd51, 1'b0, 8'h00, 8'hFF, 3'd0, 8'd79, 8'd51, 8'd0};
    vecs[7]  = '{1'b0, 7'd74, 8'd33, 1'b0, 8'h00, 8'hDF, 3'd5, 8'd79, 8'd51, 8'd33};
    vecs[8]  = '{1'b0, 7'd99, 8'd7,  1'b0, 8'h00, 8'hDF, 3'd5, 8'd79, 8'd51, 8'd33};
    vecs[9]  = '{1'b1, 7'd80, 8'd60, 1'b0, 8'hFF, 8'hFF, 3'd5, 8'd80, 8'd60, 8'd33};
    // voice 1 has aged to 9 by now, older than everyone else
    vecs[10] = '{1'b1, 7'd81, 8'd61, 1'b0, 8'hFF, 8'hFF, 3'd1, 8'd81, 8'd61, 8'd33};

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    iRST_N = 1'b1;
    #1;
    check_all_zero("reset");

    for (int i = 0; i < 3; i++) begin
      send_event(1'b1, k3[i], 8'd100, lo);
      check($sformatf("chord%0d ready_low", i), 32'(lo), 32'd9);
      check($sformatf("chord%0d adr", i), 32'(cur_key_adr), 32'(i));
      check($sformatf("chord%0d keys_on", i), 32'(keys_on), 32'((1 << (i + 1)) - 1));
      check($sformatf("chord%0d key_val", i), 32'(cur_key_val), 32'(k3[i]));
      check($sformatf("chord%0d vel_on", i), 32'(cur_vel_on), 32'd100);
      measure_pulse(plen);
      check($sformatf("chord%0d pulse_len", i), 32'(plen), 32'd1024);
    end

    for (int i = 0; i < 11; i++) begin
      sustain    = vecs[i].sus;
      voice_free = vecs[i].vf;
      send_event(vecs[i].on, vecs[i].key, vecs[i].vel, lo);
      check($sformatf("vec%0d ready_low", i), 32'(lo), 32'd9);
      check($sformatf("vec%0d keys_on", i), 32'(keys_on), 32'(vecs[i].e_keys));
      check($sformatf("vec%0d adr", i), 32'(cur_key_adr), 32'(vecs[i].e_adr));
      check($sformatf("vec%0d key_val", i), 32'(cur_key_val), 32'(vecs[i].e_val));
      check($sformatf("vec%0d vel_on", i), 32'(cur_vel_on), 32'(vecs[i].e_von));
      check($sformatf("vec%0d vel_off", i), 32'(cur_vel_off), 32'(vecs[i].e_voff));
    end

    // Sustained note-off keeps the gate until the pedal lifts.
    sustain = 1'b1;
    send_event(1'b0, 7'd81, 8'd40, lo);
    check("sus_off keys_on", 32'(keys_on), 32'hFF);
    check("sus_off adr", 32'(cur_key_adr), 32'd1);
    check("sus_off vel_off", 32'(cur_vel_off), 32'd40);
    repeat (3) @(posedge sys_clk);
    #1;
    check("sus_hold keys_on", 32'(keys_on), 32'hFF);
    @(negedge sys_clk);
    sustain = 1'b0;
    @(posedge sys_clk);
    #1;
    check("sus_release keys_on", 32'(keys_on), 32'hFD);

    // Reset while the scan is on voice 3.
    @(negedge sys_clk);
    ev_valid = 1'b1;
    ev_is_on = 1'b1;
    ev_key   = 7'd62;
    ev_vel   = 8'd77;
    @(posedge sys_clk);
    #1;
    ev_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("midscan busy", 32'(ev_ready), 32'h0);
    iRST_N = 1'b0;
    #1;
    check_all_zero("midscan_rst");
    @(negedge sys_clk);
    iRST_N = 1'b1;

    voice_free = 8'hFF;
    send_event(1'b1, 7'd60, 8'd100, lo);
    check("resend ready_low", 32'(lo), 32'd9);
    check("resend adr", 32'(cur_key_adr), 32'd0);
    check("resend keys_on", 32'(keys_on), 32'h01);
    check("resend key_val", 32'(cur_key_val), 32'd60);

    // Same key mid-pulse: retrigger voice 0 and reload, not extend, the pulse.
    repeat (100) @(posedge sys_clk);
    #1;
    send_event(1'b1, 7'd60, 8'd110, lo);
    check("retrig adr", 32'(cur_key_adr), 32'd0);
    check("retrig keys_on", 32'(keys_on), 32'h01);
    check("retrig vel_on", 32'(cur_vel_on), 32'd110);
    measure_pulse(plen);
    check("retrig pulse_len", 32'(plen), 32'd1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice allocator between the MIDI decoder and the synth engine.
- Turns note-on/note-off events into per-voice key state: keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on and cur_vel_off.
- Assignment order: retrigger a voice already holding the key, else the lowest free voice, else steal the oldest voice.
- Sustain pedal (CC64) support; voice_free comes back from the envelope generator.

Parameters:
- VOICES, 8, number of synth voices.
- V_WIDTH, 3, voice index width; VOICES <= 2**V_WIDTH.
- AGE_W, 8, width of each per-voice age counter (saturating).
- PULSE_LEN, 1024, sys_clk cycles note_on is held high after an assignment.

Ports:
- sys_clk  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_is_on  in  1  1 = note-on, 0 = note-off (note-on with velocity 0 is already converted upstream).
- ev_key  in  7  MIDI key number.
- ev_vel  in  8  velocity, used as on-velocity or off-velocity.
- sustain  in  1  pedal level, 1 = held.
- voice_free  in  VOICES  per-voice envelope-idle flags from the envelope generator.
- keys_on  out  VOICES  per-voice gate.
- note_on  out  1  stretched pulse marking a new assignment.
- cur_key_adr  out  V_WIDTH  voice touched by the last event.
- cur_key_val  out  8  key of the last event, zero-extended.
- cur_vel_on  out  8  velocity of the last note-on.
- cur_vel_off  out  8  velocity of the last note-off.

Behaviour:
- Single clock domain. Async reset on iRST_N low.
- Reset values: all outputs 0; ev_ready = 1; key table, sustain-pending flags and age counters all 0; FSM in IDLE.
- Event transfer occurs when ev_valid && ev_ready. Event fields are latched on transfer. ev_ready stays 0 from the cycle after transfer until the FSM returns to IDLE.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE -> SCAN on transfer; the scan index starts at 0.
- SCAN visits one voice per cycle, index 0..VOICES-1, and records three candidates:
  - match: lowest index v with keys_on[v] = 1 (or sustain-pending) and key[v] == ev_key.
  - free: lowest index v with keys_on[v] = 0 and voice_free[v] = 1.
  - oldest: v with the maximum age; lowest index wins a tie.
- SCAN -> COMMIT after index VOICES-1. COMMIT -> IDLE after 1 cycle.
- Latency: transfer at cycle T; outputs update at the end of COMMIT, cycle T+VOICES+1; ev_ready returns 1 at T+VOICES+2.
- Note-on commit:
  - Target voice = match if found, else free, else oldest (steal).
  - Set keys_on[target] = 1 and key[target] = ev_key; clear pending[target].
  - Set age[target] = 0; every other voice with keys_on = 1 does age+1, saturating at 2^AGE_W-1.
  - Set cur_key_adr = target, cur_key_val = {1'b0, ev_key}, cur_vel_on = ev_vel.
  - Load the stretch counter with PULSE_LEN. note_on is high while the counter is nonzero. A new commit reloads the counter; it does not extend the existing pulse additively.
- Note-off commit:
  - No match: no state change and no output change. The event is still consumed.
  - Match with sustain = 1: set pending[match] = 1; keys_on stays 1.
  - Match with sustain = 0: keys_on[match] = 0.
  - In both match cases: cur_key_adr = match, cur_vel_off = ev_vel. note_on is not pulsed.
- Sustain falling edge (registered compare): every voice with pending = 1 gets keys_on = 0 and pending = 0, in the same cycle, in any FSM state. If this coincides with a COMMIT to the same voice, the COMMIT result wins.
- A stolen voice's keys_on stays 1. The downstream envelope retriggers on note_on with the new cur_key_adr.
- voice_free is sampled during SCAN only. A change after a voice has been visited is ignored until the next event.
- Reset mid-scan aborts the event; the event is lost.

Decomposition:
- Shared package synth_pkg: VOICES/V_WIDTH defaults, the MIDI_CC_SUSTAIN constant (64), and an FSM state enum typedef alloc_state_t.
- One natural sub-module, voice_age_tracker: the per-voice saturating age counters, with inputs assign_en, assign_idx, active mask and output age array.

Test Plan:
- Reset, then note-ons for keys 60, 64, 67, all velocity 100, with voice_free = 8'hFF -> keys_on = 8'b0000_0111; cur_key_adr = 0, 1, 2 in turn; each note_on high for exactly 1024 cycles after COMMIT; ev_ready low for exactly 9 cycles per event.
- 9 distinct note-ons with voice_free = 8'h00 after the 8th -> the 9th steals voice 0 (oldest): cur_key_adr = 0, cur_key_val = 9th key, keys_on = 8'hFF.
- Note-on key 60 twice -> the second returns cur_key_adr = 0 (retrigger) and note_on reloads; keys_on unchanged.
- sustain = 1, note-off key 60 velocity 40 -> keys_on[0] stays 1 and cur_vel_off = 40. sustain -> 0 -> keys_on[0] = 0 on the next cycle.
- Note-off for key 99, which is never played -> all outputs unchanged and ev_ready = 1 after 9 cycles.
- Assert iRST_N = 0 at scan index 3 -> all outputs 0 and ev_ready = 1 immediately. Release reset and re-send the event -> allocated to voice 0.
